// File: rtl/io_pkg.sv
// Shared IO-bus port IDs, status-byte layout and UART transmitter state encoding.
package io_pkg;

  localparam logic [7:0] PORT_ID_UART_DATA   = 8'h01;
  localparam logic [7:0] PORT_ID_UART_STATUS = 8'h03;

  localparam int unsigned STAT_FULL     = 0;
  localparam int unsigned STAT_EMPTY    = 1;
  localparam int unsigned STAT_ACTIVE   = 2;
  localparam int unsigned STAT_OVERFLOW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_tx_state_e;

  function automatic logic [7:0] pack_status(input logic overflow, input logic active,
                                             input logic empty, input logic full);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_OVERFLOW] = overflow;
    s[STAT_ACTIVE]   = active;
    s[STAT_EMPTY]    = empty;
    s[STAT_FULL]     = full;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; rdata shows the head entry combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// IO-port mapped UART transmitter: byte writes feed a FIFO drained by an 8N1 serializer,
// with a combinational status port that reads zero when not addressed.
module io_uart_tx
  import io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [7:0]  PORT_DATA    = PORT_ID_UART_DATA,
  parameter logic [7:0]  PORT_STATUS  = PORT_ID_UART_STATUS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  output logic       UART_TX_out
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  uart_tx_state_e   state;
  logic [BaudW-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             tx_line;
  logic             overflow;

  logic       wr_hit;
  logic       rd_hit;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       tx_active;
  logic       baud_last;

  assign wr_hit    = IO_write_strobe && (IO_port_ID == PORT_DATA);
  assign rd_hit    = IO_read_strobe && (IO_port_ID == PORT_STATUS);
  assign fifo_push = wr_hit && !fifo_full;
  assign fifo_pop  = (state == StIdle) && !fifo_empty;
  assign tx_active = (state != StIdle);
  assign baud_last = (baud_cnt == BaudLast);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(IO_write_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_line   <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (!fifo_empty) begin
            shift_reg <= fifo_rdata;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            tx_line   <= 1'b0;
            state     <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            tx_line   <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            state     <= StData;
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_line <= 1'b1;
              state   <= StStop;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              tx_line   <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= StIdle;
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // A dropped write outranks the clear-on-read so the event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_hit && fifo_full) begin
      overflow <= 1'b1;
    end else if (rd_hit) begin
      overflow <= 1'b0;
    end
  end

  always_comb begin
    IO_read_data = 8'h00;
    if (rd_hit) begin
      IO_read_data = pack_status(overflow, tx_active, fifo_empty, fifo_full);
    end
  end

  assign UART_TX_out = tx_line;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: frame-level reference model checked every cycle, a serial
// decoder, and directed literal expectations.
module tb_io_uart_tx;

  localparam int CPB   = 104;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] IO_port_ID = 8'h00;
  logic [7:0] IO_write_data = 8'h00;
  logic       IO_write_strobe = 1'b0;
  logic       IO_read_strobe = 1'b0;
  logic [7:0] IO_read_data;
  logic       UART_TX_out;

  int checks = 0;
  int errors = 0;

  io_uart_tx dut (
    .clk            (clk),
    .reset          (reset),
    .IO_port_ID     (IO_port_ID),
    .IO_write_data  (IO_write_data),
    .IO_write_strobe(IO_write_strobe),
    .IO_read_strobe (IO_read_strobe),
    .IO_read_data   (IO_read_data),
    .UART_TX_out    (UART_TX_out)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus cycle offset within the current frame.
  logic [7:0] m_q[$];
  logic       m_ovf;
  logic       m_busy;
  int         m_fcyc;
  logic [7:0] m_cur;
  logic       m_wr;
  logic       m_rd;
  logic       m_was_full;
  logic       m_was_empty;

  initial begin
    m_ovf  = 1'b0;
    m_busy = 1'b0;
    m_fcyc = 0;
    m_cur  = 8'h00;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        m_fcyc = 0;
      end else begin
        m_wr        = IO_write_strobe && (IO_port_ID == 8'h01);
        m_rd        = IO_read_strobe && (IO_port_ID == 8'h03);
        m_was_full  = (m_q.size() == DEPTH);
        m_was_empty = (m_q.size() == 0);
        if (m_busy) begin
          m_fcyc++;
          if (m_fcyc == 10 * CPB) m_busy = 1'b0;
        end else if (!m_was_empty) begin
          m_cur  = m_q.pop_front();
          m_busy = 1'b1;
          m_fcyc = 0;
        end
        if (m_wr && m_was_full) m_ovf = 1'b1;
        else if (m_rd) m_ovf = 1'b0;
        if (m_wr && !m_was_full) m_q.push_back(IO_write_data);
      end
    end
  end

  function automatic logic exp_line();
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_fcyc / CPB;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  function automatic logic [7:0] exp_status();
    return {4'b0000, m_ovf, m_busy, (m_q.size() == 0), (m_q.size() == DEPTH)};
  endfunction

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle line comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) chk_bit("line vs model", UART_TX_out, exp_line());
    end
  end

  // Serial decoder: samples mid-bit, discards frames cut by a reset.
  logic [7:0] rx_q[$];
  int         rst_cnt = 0;

  initial begin
    forever begin
      @(posedge reset);
      rst_cnt++;
    end
  end

  initial begin : decoder
    logic [7:0] b;
    int         r0;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && UART_TX_out === 1'b0) begin
        r0 = rst_cnt;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = UART_TX_out;
        end
        repeat (CPB) @(negedge clk);
        if (rst_cnt == r0) rx_q.push_back(b);
      end
    end
  end

  task automatic advance(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; holds the write for exactly one rising edge.
  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    IO_port_ID      = port;
    IO_write_data   = data;
    IO_write_strobe = 1'b1;
    @(negedge clk);
    IO_write_strobe = 1'b0;
  endtask

  task automatic status_read(input logic [7:0] port, input logic [7:0] want, input string name);
    IO_port_ID     = port;
    IO_read_strobe = 1'b1;
    #1;
    chk8({name, " (model)"}, IO_read_data, (port == 8'h03) ? exp_status() : 8'h00);
    chk8(name, IO_read_data, want);
    @(negedge clk);
    IO_read_strobe = 1'b0;
  endtask

  logic [7:0] want;
  logic [7:0] fill;
  int         lows;

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk_bit("line held in reset", UART_TX_out, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    chk_bit("line after reset", UART_TX_out, 1'b1);
    status_read(8'h03, 8'h02, "status after reset");

    // Single 0x55 frame with exact timing.
    rx_q.delete();
    io_write(8'h01, 8'h55);
    chk_bit("line before pop", UART_TX_out, 1'b1);
    advance(1);
    chk_bit("start bit low", UART_TX_out, 1'b0);
    advance(CPB / 2);
    chk_bit("start mid", UART_TX_out, 1'b0);
    want = 8'h55;
    for (int i = 0; i < 8; i++) begin
      advance(CPB);
      chk_bit($sformatf("0x55 bit%0d", i), UART_TX_out, want[i]);
    end
    advance(CPB);
    chk_bit("0x55 stop", UART_TX_out, 1'b1);
    advance(CPB / 2 - 1);
    status_read(8'h03, 8'h06, "status last stop cycle");
    status_read(8'h03, 8'h02, "status frame done");
    chk_int("rx count 0x55", rx_q.size(), 1);
    chk8("rx byte 0x55", rx_q[0], 8'h55);

    // Back-to-back frames.
    rx_q.delete();
    io_write(8'h01, 8'hA1);
    io_write(8'h01, 8'h3C);
    chk_bit("A1 start", UART_TX_out, 1'b0);
    advance(10 * CPB);
    chk_bit("gap cycle high", UART_TX_out, 1'b1);
    advance(1);
    chk_bit("3C start after gap", UART_TX_out, 1'b0);
    advance(10 * CPB + 2);
    chk_int("rx count pair", rx_q.size(), 2);
    chk8("rx first", rx_q[0], 8'hA1);
    chk8("rx second", rx_q[1], 8'h3C);

    // Address decode.
    status_read(8'h02, 8'h00, "status wrong port");
    status_read(8'h01, 8'h00, "read of data port");
    io_write(8'h04, 8'h77);
    status_read(8'h03, 8'h02, "status after foreign write");
    advance(3 * CPB);
    chk_bit("no frame from foreign write", UART_TX_out, 1'b1);

    // Overflow while busy.
    rx_q.delete();
    io_write(8'h01, 8'hFF);
    for (int i = 0; i < 17; i++) begin
      fill = 8'(8'h10 + i);
      io_write(8'h01, fill);
    end
    status_read(8'h03, 8'h0D, "status overflow full");
    status_read(8'h03, 8'h05, "status overflow cleared");
    advance(17 * (10 * CPB + 1) + CPB);
    chk_int("rx count overflow run", rx_q.size(), 17);
    chk8("rx busy byte", rx_q[0], 8'hFF);
    for (int i = 0; i < 16; i++) begin
      fill = 8'(8'h10 + i);
      chk8($sformatf("rx fifo byte %0d", i), rx_q[i+1], fill);
    end
    status_read(8'h03, 8'h02, "status drained");

    // Reset in the middle of bit 4.
    rx_q.delete();
    io_write(8'h01, 8'h4A);
    io_write(8'h01, 8'h11);
    io_write(8'h01, 8'h22);
    advance(5 * CPB + CPB / 2 - 1);
    chk_bit("bit4 low before reset", UART_TX_out, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_bit("line high in reset cycle", UART_TX_out, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    status_read(8'h03, 8'h02, "status after mid-frame reset");
    lows = 0;
    repeat (25 * CPB) begin
      @(negedge clk);
      if (UART_TX_out !== 1'b1) lows++;
    end
    chk_int("line idle after reset", lows, 0);
    chk_int("no bytes after reset", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
